// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - parametrised up/down counter with programmable rollover, load, one-shot halt and wrap pulse
module flex_counter #(
    parameter int unsigned NUM_BITS = 4,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                enable,
    input  logic                clear,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    input  logic                up_down,
    input  logic                one_shot,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count,
    output logic                overflow_flag,
    output logic                wrap_pulse,
    output logic                done
);

    localparam logic [NUM_BITS-1:0] RST_CNT = RST_VAL[NUM_BITS-1:0];
    localparam logic [NUM_BITS-1:0] ONE     = {{(NUM_BITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                wrap_q, wrap_d;
    logic                done_q, done_d;

    logic [NUM_BITS-1:0] terminal;
    logic                at_end;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= RUN;
            count_q    <= RST_CNT;
            overflow_q <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wrap_d   = 1'b0;
        terminal = up_down ? rollover_val : '0;
        // Counting up, anything at or beyond the bound is treated as the end of range
        at_end   = up_down ? (count_q >= rollover_val) : (count_q == '0);

        if (clear) begin
            count_d = RST_CNT;
            state_d = RUN;
        end else if (load) begin
            count_d = load_val;
            state_d = RUN;
        end else if (enable && (state_q == RUN)) begin
            if (at_end) begin
                if (one_shot) begin
                    state_d = HALT;
                end else begin
                    count_d = up_down ? '0 : rollover_val;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = up_down ? (count_q + ONE) : (count_q - ONE);
            end
        end

        overflow_d = (count_d == terminal);
        done_d     = (state_d == HALT);
    end

    assign count         = count_q;
    assign overflow_flag = overflow_q;
    assign wrap_pulse    = wrap_q;
    assign done          = done_q;

endmodule

// File: tb/tb_flex_counter.sv
// tb/tb_flex_counter.sv - directed self-checking bench for flex_counter
module tb_flex_counter;

    logic       clk = 1'b0;
    logic       nrst;
    logic       enable, clear, load, up_down, one_shot;
    logic [3:0] load_val, rollover_val;
    logic [3:0] count;
    logic       overflow_flag, wrap_pulse, done;

    int vectors = 0;
    int errors  = 0;

    flex_counter #(.NUM_BITS(4), .RST_VAL(0)) dut (
        .clk(clk), .nrst(nrst), .enable(enable), .clear(clear), .load(load),
        .load_val(load_val), .up_down(up_down), .one_shot(one_shot),
        .rollover_val(rollover_val), .count(count), .overflow_flag(overflow_flag),
        .wrap_pulse(wrap_pulse), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nrst = 1'b0; enable = 0; clear = 0; load = 0; up_down = 1; one_shot = 0;
        load_val = 4'd0; rollover_val = 4'd9;
        #12;
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: cnt=%0d ovf=%b wrap=%b done=%b want 0 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_up_wrap;
        logic [3:0] ec;
        up_down = 1; rollover_val = 4'd9; one_shot = 0; enable = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            ec = 4'((i + 1) % 10);
            vectors++;
            if ({count, overflow_flag, wrap_pulse, done} !== {ec, ec == 4'd9, i == 9, 1'b0}) begin
                errors++;
                $display("FAIL up_wrap[%0d]: cnt=%0d ovf=%b wrap=%b done=%b want %0d %b %b 0",
                         i, count, overflow_flag, wrap_pulse, done, ec, ec == 4'd9, i == 9);
            end
        end
        enable = 0;
    endtask

    task automatic test_down;
        logic [3:0] seq [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        up_down = 0; rollover_val = 4'd9; load = 1; load_val = 4'd3; enable = 0;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd3, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL down_load: cnt=%0d ovf=%b wrap=%b done=%b want 3 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        load = 0; enable = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({count, overflow_flag, wrap_pulse, done} !== {seq[i], seq[i] == 4'd0, i == 3, 1'b0}) begin
                errors++;
                $display("FAIL down[%0d]: cnt=%0d ovf=%b wrap=%b done=%b want %0d %b %b 0",
                         i, count, overflow_flag, wrap_pulse, done, seq[i], seq[i] == 4'd0, i == 3);
            end
        end
        enable = 0;
    endtask

    task automatic test_one_shot;
        up_down = 1; rollover_val = 4'd5; one_shot = 1; enable = 0; clear = 1;
        tick();
        clear = 0; enable = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if ({count, overflow_flag, wrap_pulse, done} !== {4'(i), i == 5, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL oneshot_run[%0d]: cnt=%0d ovf=%b wrap=%b done=%b want %0d %b 0 0",
                         i, count, overflow_flag, wrap_pulse, done, i, i == 5);
            end
        end
        for (int i = 0; i < 11; i++) begin
            tick();
            vectors++;
            if ({count, overflow_flag, wrap_pulse, done} !== {4'd5, 1'b1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL oneshot_halt[%0d]: cnt=%0d ovf=%b wrap=%b done=%b want 5 1 0 1",
                         i, count, overflow_flag, wrap_pulse, done);
            end
        end
        load = 1; load_val = 4'd2;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd2, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL oneshot_load: cnt=%0d ovf=%b wrap=%b done=%b want 2 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        load = 0;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd3, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL oneshot_resume: cnt=%0d ovf=%b wrap=%b done=%b want 3 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        enable = 0; one_shot = 0;
    endtask

    task automatic test_priority;
        up_down = 1; rollover_val = 4'd7; one_shot = 1; enable = 0; load = 1; load_val = 4'd7;
        tick();
        load = 0; enable = 1;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd7, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL prio_halt: cnt=%0d ovf=%b wrap=%b done=%b want 7 1 0 1",
                     count, overflow_flag, wrap_pulse, done);
        end
        clear = 1; load = 1; load_val = 4'd3;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL prio_clear: cnt=%0d ovf=%b wrap=%b done=%b want 0 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        clear = 0; load = 0; enable = 0; one_shot = 0;
    endtask

    task automatic test_out_of_range;
        up_down = 1; rollover_val = 4'd9; one_shot = 0; enable = 0; load = 1; load_val = 4'd14;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd14, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL oor_load: cnt=%0d ovf=%b wrap=%b done=%b want 14 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        load = 0; enable = 1;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL oor_wrap: cnt=%0d ovf=%b wrap=%b done=%b want 0 0 1 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        rollover_val = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({count, overflow_flag, wrap_pulse, done} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL roll0[%0d]: cnt=%0d ovf=%b wrap=%b done=%b want 0 1 1 0",
                         i, count, overflow_flag, wrap_pulse, done);
            end
        end
        enable = 0; load = 1; load_val = 4'd14; up_down = 0; rollover_val = 4'd9;
        tick();
        load = 0; enable = 1;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd13, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL oor_down: cnt=%0d ovf=%b wrap=%b done=%b want 13 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        enable = 0;
    endtask

    task automatic test_async_reset;
        up_down = 1; rollover_val = 4'd9; one_shot = 0; enable = 0; load = 1; load_val = 4'd5;
        tick();
        load = 0; enable = 1;
        tick();
        vectors++;
        if (count !== 4'd6) begin
            errors++;
            $display("FAIL arst_pre: cnt=%0d want 6", count);
        end
        #1 nrst = 1'b0;
        #1;
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL arst_mid: cnt=%0d ovf=%b wrap=%b done=%b want 0 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        #2 nrst = 1'b1;
        tick();
        vectors++;
        if ({count, overflow_flag, wrap_pulse, done} !== {4'd1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL arst_post: cnt=%0d ovf=%b wrap=%b done=%b want 1 0 0 0",
                     count, overflow_flag, wrap_pulse, done);
        end
        enable = 0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down();
        test_one_shot();
        test_priority();
        test_out_of_range();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
